// File: rtl/eth_send_pkt_buf_if.sv
// Write/read bundle between the frame assembler / MAC transmit path and the
// multi-slot transmit packet buffer.
interface eth_send_pkt_buf_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
);
  logic                  WrEn;
  logic [DATA_WIDTH-1:0] WrData;
  logic                  WrLast;
  logic                  WrAbort;
  logic                  WrReady;
  logic                  WrDrop;
  logic                  RdPktAvail;
  logic [ADDR_WIDTH:0]   RdLen;
  logic                  RdEn;
  logic [DATA_WIDTH-1:0] Q;
  logic                  QValid;
  logic                  QLast;

  modport master (
    output WrEn, WrData, WrLast, WrAbort, RdEn,
    input  WrReady, WrDrop, RdPktAvail, RdLen, Q, QValid, QLast
  );

  modport slave (
    input  WrEn, WrData, WrLast, WrAbort, RdEn,
    output WrReady, WrDrop, RdPktAvail, RdLen, Q, QValid, QLast
  );
endinterface

// File: rtl/eth_send_pkt_buf.sv
// Multi-slot Ethernet transmit packet buffer: whole frames committed on WrLast, popped in order.
// Optional minimum-size padding of reported/read frames is enabled by ETH_SEND_BUF_PAD_EN.
module eth_send_pkt_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int SLOT_BITS  = 1
) (
  input logic               Clock,
  input logic               Reset,
  eth_send_pkt_buf_if.slave bus
);
  localparam int NUM_SLOTS = 1 << SLOT_BITS;
  localparam int DEPTH     = 1 << (ADDR_WIDTH + SLOT_BITS);

  typedef logic [ADDR_WIDTH:0]  len_t;
  typedef logic [SLOT_BITS-1:0] slot_t;
  typedef logic [SLOT_BITS:0]   cnt_t;

  localparam len_t  LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam len_t  LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam len_t  LEN_CAP  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam slot_t SLOT_ONE = {{(SLOT_BITS-1){1'b0}}, 1'b1};
  localparam cnt_t  CNT_ZERO = {(SLOT_BITS+1){1'b0}};
  localparam cnt_t  CNT_ONE  = {{SLOT_BITS{1'b0}}, 1'b1};
`ifdef ETH_SEND_BUF_PAD_EN
  localparam len_t  MIN_LEN  = len_t'(7'd60);
`endif

  function automatic len_t report_len(input len_t stored);
`ifdef ETH_SEND_BUF_PAD_EN
    if ((stored != LEN_ZERO) && (stored < MIN_LEN)) begin
      report_len = MIN_LEN;
    end else begin
      report_len = stored;
    end
`else
    report_len = stored;
`endif
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  len_t                  len_q [NUM_SLOTS];

  slot_t wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  len_t  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t  count_q, count_d;
  logic  in_frame_q, in_frame_d, drop_q, drop_d;
  logic  wr_ready_q, wr_ready_d, wr_drop_q, wr_drop_d;
  logic  rd_avail_q, rd_avail_d, q_valid_q, q_valid_d, q_last_q, q_last_d;
  len_t  rd_len_q, rd_len_d, head_len_s;
  logic [DATA_WIDTH-1:0] q_q;

  logic wr_act_s, mark_s, ovf_s, discard_s, store_s, commit_s;
  logic rd_fire_s, rd_last_s, rd_mem_s;
  len_t commit_len_s;

  // A frame's fate is decided by its first byte; later bytes inherit the mark.
  assign wr_act_s     = bus.WrEn & ~bus.WrAbort;
  assign mark_s       = in_frame_q ? drop_q : count_q[SLOT_BITS];
  assign ovf_s        = ~mark_s & (wr_ptr_q == LEN_CAP);
  assign discard_s    = mark_s | ovf_s;
  assign store_s      = wr_act_s & ~discard_s;
  assign commit_s     = store_s & bus.WrLast;
  assign commit_len_s = wr_ptr_q + LEN_ONE;

  assign rd_fire_s = bus.RdEn & (count_q != CNT_ZERO);
  assign rd_last_s = rd_fire_s & (rd_ptr_q == (rd_len_q - LEN_ONE));
`ifdef ETH_SEND_BUF_PAD_EN
  assign rd_mem_s  = rd_fire_s & (rd_ptr_q < len_q[rd_slot_q]);
`else
  assign rd_mem_s  = rd_fire_s;
`endif

  // Next-state for pointers, occupancy and registered status outputs.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    in_frame_d = in_frame_q;
    drop_d     = drop_q;
    if (bus.WrAbort) begin
      wr_ptr_d   = LEN_ZERO;
      in_frame_d = 1'b0;
      drop_d     = 1'b0;
    end else if (bus.WrEn && bus.WrLast) begin
      wr_ptr_d   = LEN_ZERO;
      in_frame_d = 1'b0;
      drop_d     = 1'b0;
    end else if (bus.WrEn) begin
      wr_ptr_d   = store_s ? commit_len_s : wr_ptr_q;
      in_frame_d = 1'b1;
      drop_d     = discard_s;
    end else begin
      wr_ptr_d   = wr_ptr_q;
    end

    wr_drop_d = wr_act_s & bus.WrLast & discard_s;
    wr_slot_d = commit_s ? (wr_slot_q + SLOT_ONE) : wr_slot_q;

    if (rd_last_s) begin
      rd_ptr_d = LEN_ZERO;
    end else if (rd_fire_s) begin
      rd_ptr_d = rd_ptr_q + LEN_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    rd_slot_d = rd_last_s ? (rd_slot_q + SLOT_ONE) : rd_slot_q;

    case ({commit_s, rd_last_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // The head slot may be the one committing this very cycle.
    if (commit_s && (wr_slot_q == rd_slot_d)) begin
      head_len_s = commit_len_s;
    end else begin
      head_len_s = len_q[rd_slot_d];
    end

    wr_ready_d = ~count_d[SLOT_BITS];
    rd_avail_d = (count_d != CNT_ZERO);
    rd_len_d   = report_len(head_len_s);
    q_valid_d  = rd_fire_s;
    q_last_d   = rd_last_s;
  end

  // Control and status registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_slot_q  <= '0;
      rd_slot_q  <= '0;
      wr_ptr_q   <= LEN_ZERO;
      rd_ptr_q   <= LEN_ZERO;
      count_q    <= CNT_ZERO;
      in_frame_q <= 1'b0;
      drop_q     <= 1'b0;
      wr_ready_q <= 1'b1;
      wr_drop_q  <= 1'b0;
      rd_avail_q <= 1'b0;
      rd_len_q   <= LEN_ZERO;
      q_valid_q  <= 1'b0;
      q_last_q   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        len_q[i] <= LEN_ZERO;
      end
    end else begin
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_frame_q <= in_frame_d;
      drop_q     <= drop_d;
      wr_ready_q <= wr_ready_d;
      wr_drop_q  <= wr_drop_d;
      rd_avail_q <= rd_avail_d;
      rd_len_q   <= rd_len_d;
      q_valid_q  <= q_valid_d;
      q_last_q   <= q_last_d;
      if (commit_s) begin
        len_q[wr_slot_q] <= commit_len_s;
      end
    end
  end

  // Frame storage write port.
  always_ff @(posedge Clock) begin
    if (store_s) begin
      mem_q[{wr_slot_q, wr_ptr_q[ADDR_WIDTH-1:0]}] <= bus.WrData;
    end
  end

  // Registered read port; padding bytes beyond the stored length read as zero.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q <= '0;
    end else if (rd_mem_s) begin
      q_q <= mem_q[{rd_slot_q, rd_ptr_q[ADDR_WIDTH-1:0]}];
    end else if (rd_fire_s) begin
      q_q <= '0;
    end
  end

  assign bus.WrReady    = wr_ready_q;
  assign bus.WrDrop     = wr_drop_q;
  assign bus.RdPktAvail = rd_avail_q;
  assign bus.RdLen      = rd_len_q;
  assign bus.Q          = q_q;
  assign bus.QValid     = q_valid_q;
  assign bus.QLast      = q_last_q;
endmodule

// File: tb/tb_eth_send_pkt_buf.sv
// Scoreboard bench for eth_send_pkt_buf (ADDR_WIDTH=7, two slots); expected RdLen
// follows ETH_SEND_BUF_PAD_EN when the bench is built with it.
module tb_eth_send_pkt_buf;
  localparam int AW = 7;
`ifdef ETH_SEND_BUF_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  eth_send_pkt_buf_if #(.DATA_WIDTH(8), .ADDR_WIDTH(AW)) bus();

  eth_send_pkt_buf #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .SLOT_BITS(1)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;
  int drops    = 0;
  logic [8:0] exp_q [$];
  logic [8:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic int rep_len(input int l);
    return (PAD && l < 60) ? 60 : l;
  endfunction

  function automatic logic [8:0] exp_byte(input int len, input logic [7:0] base, input int i, input int n);
    logic [7:0] d;
    d = (i < len) ? base + 8'(i) : 8'h00;
    return {(i == n - 1), d};
  endfunction

  // Monitor: pop and compare on every valid read byte, count drop pulses.
  always @(negedge Clock) begin
    if (bus.WrDrop === 1'b1) drops++;
    if (bus.QValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: QValid with no expected byte, Q=0x%0h", bus.Q);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", 32'(bus.Q), 32'(mon_e[7:0]));
        chk("rd_last", 32'(bus.QLast), 32'(mon_e[8]));
      end
    end
  end

  task automatic wr_byte(input logic [7:0] d, input logic last);
    bus.WrEn = 1'b1; bus.WrData = d; bus.WrLast = last;
    @(posedge Clock); #1;
    bus.WrEn = 1'b0; bus.WrLast = 1'b0;
  endtask

  task automatic wr_frame(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) wr_byte(base + 8'(i), (i == len - 1));
  endtask

  task automatic rd_frame(input int len, input logic [7:0] base);
    int n;
    n = rep_len(len);
    for (int i = 0; i < n; i++) begin
      bus.RdEn = 1'b1;
      exp_q.push_back(exp_byte(len, base, i, n));
      @(posedge Clock); #1;
    end
    bus.RdEn = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge Clock);
    #1;
    chk("sb_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.WrEn = 1'b0; bus.WrData = 8'h00; bus.WrLast = 1'b0;
    bus.WrAbort = 1'b0; bus.RdEn = 1'b0;
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_wr_ready", 32'(bus.WrReady), 32'd1);
    chk("rst_wr_drop", 32'(bus.WrDrop), 32'd0);
    chk("rst_avail", 32'(bus.RdPktAvail), 32'd0);
    chk("rst_rdlen", 32'(bus.RdLen), 32'd0);
    chk("rst_q", 32'(bus.Q), 32'd0);
    chk("rst_qvalid", 32'(bus.QValid), 32'd0);
    chk("rst_qlast", 32'(bus.QLast), 32'd0);
    Reset = 1'b0;

    // 64-byte frame, then an ignored read on an empty buffer
    wr_frame(64, 8'h00);
    chk("t1_avail", 32'(bus.RdPktAvail), 32'd1);
    chk("t1_rdlen", 32'(bus.RdLen), 32'd64);
    chk("t1_wr_ready", 32'(bus.WrReady), 32'd1);
    rd_frame(64, 8'h00);
    chk("t1_avail_after", 32'(bus.RdPktAvail), 32'd0);
    drain();
    bus.RdEn = 1'b1;
    @(posedge Clock); #1;
    bus.RdEn = 1'b0;
    chk("empty_rd_qvalid", 32'(bus.QValid), 32'd0);
    chk("q_hold", 32'(bus.Q), 32'h3F);

    // Full buffer: third frame discarded, back-to-back reads
    wr_frame(100, 8'h10);
    chk("t2_ready_one", 32'(bus.WrReady), 32'd1);
    wr_frame(100, 8'h80);
    chk("t2_ready_full", 32'(bus.WrReady), 32'd0);
    wr_frame(30, 8'hC0);
    repeat (2) @(posedge Clock); #1;
    chk("t2_drop_cnt", drops, 32'd1);
    chk("t2_ready_still0", 32'(bus.WrReady), 32'd0);
    chk("t2_rdlen", 32'(bus.RdLen), 32'd100);
    rd_frame(100, 8'h10);
    chk("t2_ready_freed", 32'(bus.WrReady), 32'd1);
    chk("t2_rdlen_next", 32'(bus.RdLen), 32'd100);
    rd_frame(100, 8'h80);
    chk("t2_avail_after", 32'(bus.RdPktAvail), 32'd0);
    drain();

    // Overflow at capacity+1 bytes, then an exactly-full frame
    wr_frame(129, 8'h00);
    repeat (2) @(posedge Clock); #1;
    chk("t3_drop_cnt", drops, 32'd2);
    chk("t3_avail", 32'(bus.RdPktAvail), 32'd0);
    wr_frame(128, 8'h55);
    chk("t3_rdlen_cap", 32'(bus.RdLen), 32'd128);
    rd_frame(128, 8'h55);
    drain();

    // Abort after 10 bytes; abort wins over a simultaneous WrEn/WrLast
    for (int i = 0; i < 10; i++) wr_byte(8'hE0 + 8'(i), 1'b0);
    bus.WrAbort = 1'b1; bus.WrEn = 1'b1; bus.WrLast = 1'b1; bus.WrData = 8'hEE;
    @(posedge Clock); #1;
    bus.WrAbort = 1'b0; bus.WrEn = 1'b0; bus.WrLast = 1'b0;
    chk("t4_avail_none", 32'(bus.RdPktAvail), 32'd0);
    wr_frame(5, 8'h20);
    repeat (2) @(posedge Clock); #1;
    chk("t4_no_drop", drops, 32'd2);
    chk("t4_rdlen", 32'(bus.RdLen), 32'(rep_len(5)));
    rd_frame(5, 8'h20);
    drain();

    // Short frame (padding boundary)
    wr_frame(20, 8'h40);
    chk("t5_rdlen", 32'(bus.RdLen), 32'(rep_len(20)));
    rd_frame(20, 8'h40);
    drain();

    // Commit and last-byte read in the same cycle
    wr_frame(4, 8'hA0);
    n = rep_len(4);
    for (int i = 0; i < n; i++) begin
      bus.WrEn = 1'b1; bus.WrData = 8'hB0 + 8'(i); bus.WrLast = (i == n - 1);
      bus.RdEn = 1'b1;
      exp_q.push_back(exp_byte(4, 8'hA0, i, n));
      @(posedge Clock); #1;
    end
    bus.WrEn = 1'b0; bus.WrLast = 1'b0; bus.RdEn = 1'b0;
    chk("t6_avail", 32'(bus.RdPktAvail), 32'd1);
    chk("t6_rdlen", 32'(bus.RdLen), 32'(rep_len(n)));
    chk("t6_ready", 32'(bus.WrReady), 32'd1);
    rd_frame(n, 8'hB0);
    drain();

    // Reset while reading byte 3 of 8 with another frame queued
    wr_frame(8, 8'h60);
    wr_frame(8, 8'h70);
    n = rep_len(8);
    for (int i = 0; i < 3; i++) begin
      bus.RdEn = 1'b1;
      exp_q.push_back(exp_byte(8, 8'h60, i, n));
      @(posedge Clock); #1;
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
    bus.RdEn = 1'b0;
    chk("t7_avail", 32'(bus.RdPktAvail), 32'd0);
    chk("t7_qvalid", 32'(bus.QValid), 32'd0);
    chk("t7_ready", 32'(bus.WrReady), 32'd1);
    chk("t7_rdlen", 32'(bus.RdLen), 32'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;
    chk("t7_no_drop", drops, 32'd2);
    wr_frame(3, 8'h90);
    chk("t7_rdlen_new", 32'(bus.RdLen), 32'(rep_len(3)));
    rd_frame(3, 8'h90);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
